// File: rtl/obstacle_scroller.sv
// obstacle_scroller
//   Generates and scrolls three pipe obstacles for the pixel colour driver.
//   A tick counter paces the scroll. On each tick every pipe moves left by
//   STEP px. A pipe that has fully left the screen is respawned one ring
//   (3*SPACING) further right with a fresh LFSR gap. Passing the bird
//   column raises a one-cycle score pulse. Collision freezes everything
//   until start is asserted again.
//
// Ports
//   clk                 system clock
//   reset               asynchronous, active-low
//   start               begin play (IDLE) / restart (HALT)
//   collision           halts scrolling, beats start
//   finalObsLeft1..3    pipe left x, clamped to 0
//   finalObsRight1..3   pipe right x (left+OBS_W-1), clamped to 0
//   finalYTop1..3       gap top y
//   finalYBot1..3       gap bottom y (YTop+GAP_H)
//   running             high while scrolling
//   scored              one-cycle pulse per pipe passed
//   score               pipes passed, saturating at 255
//
// state  | meaning
// S_IDLE | pipes parked at reset positions, waiting for start
// S_RUN  | counting ticks and scrolling
// S_HALT | frozen after collision, waiting for start without collision

module obstacle_scroller #(
  parameter int          SCREEN_W = 640,
  parameter int          SCREEN_H = 480,
  parameter int          OBS_W    = 40,
  parameter int          SPACING  = 160,
  parameter int          GAP_H    = 120,
  parameter int          GAP_MIN  = 40,
  parameter int          STEP     = 2,
  parameter int          TICK_DIV = 250000,
  parameter int          BIRD_X   = 100,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       collision,
  output logic [9:0] finalObsLeft1,
  output logic [9:0] finalObsLeft2,
  output logic [9:0] finalObsLeft3,
  output logic [9:0] finalObsRight1,
  output logic [9:0] finalObsRight2,
  output logic [9:0] finalObsRight3,
  output logic [8:0] finalYTop1,
  output logic [8:0] finalYTop2,
  output logic [8:0] finalYTop3,
  output logic [8:0] finalYBot1,
  output logic [8:0] finalYBot2,
  output logic [8:0] finalYBot3,
  output logic       running,
  output logic       scored,
  output logic [7:0] score
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam int                CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [15:0]       SEED_I    = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic signed [10:0] STEP_C   = 11'(STEP);
  localparam logic signed [10:0] OBSW_C   = 11'(OBS_W);
  localparam logic signed [10:0] BIRD_C   = 11'(BIRD_X);
  localparam logic signed [10:0] RING_C   = 11'(3 * SPACING);
  localparam logic [8:0]        YTOP_INIT = 9'((SCREEN_H - GAP_H) / 2);
  localparam logic [8:0]        GAP_H_C   = 9'(GAP_H);
  localparam logic [8:0]        GAP_MIN_C = 9'(GAP_MIN);

  function automatic logic signed [10:0] p_init(input int i);
    return 11'(SCREEN_W + i * SPACING);
  endfunction

  // Negative x is pinned to 0; anything right of the screen passes through.
  function automatic logic [9:0] clamp(input logic signed [10:0] v);
    return v[10] ? 10'd0 : v[9:0];
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [7:0]          score_q, score_d;
  logic                scored_q, scored_d;
  logic                running_q, running_d;
  logic signed [10:0]  p_q [3];
  logic signed [10:0]  p_d [3];
  logic signed [10:0]  moved [3];
  logic [8:0]          ytop_q [3];
  logic [8:0]          ytop_d [3];
  logic [8:0]          ybot_q [3];
  logic [8:0]          ybot_d [3];
  logic [9:0]          left_q [3];
  logic [9:0]          left_d [3];
  logic [9:0]          right_q [3];
  logic [9:0]          right_d [3];
  logic                step_en, reload, passed;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    scored_d = 1'b0;
    step_en  = 1'b0;
    reload   = 1'b0;
    passed   = 1'b0;
    // Galois form, taps x^16+x^14+x^13+x^11; free-running in every state.
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Collision wins over a coinciding tick: no step, counter frozen.
        if (collision) begin
          state_d = S_HALT;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          step_en = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HALT: begin
        if (start && !collision) begin
          state_d = S_RUN;
          cnt_d   = '0;
          score_d = '0;
          reload  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < 3; i++) begin
      p_d[i]    = p_q[i];
      ytop_d[i] = ytop_q[i];
      ybot_d[i] = ybot_q[i];
      moved[i]  = p_q[i] - STEP_C;
      if (step_en) begin
        // Score uses the moved position before any respawn wrap.
        if ((p_q[i] + OBSW_C - 11'sd1 >= BIRD_C) &&
            (moved[i] + OBSW_C - 11'sd1 < BIRD_C)) begin
          passed = 1'b1;
        end
        if (moved[i] + OBSW_C <= 11'sd0) begin
          p_d[i]    = moved[i] + RING_C;
          ytop_d[i] = GAP_MIN_C + {1'b0, lfsr_q[7:0]};
          ybot_d[i] = GAP_MIN_C + {1'b0, lfsr_q[7:0]} + GAP_H_C;
        end else begin
          p_d[i] = moved[i];
        end
      end
      if (reload) begin
        p_d[i]    = p_init(i);
        ytop_d[i] = YTOP_INIT;
        ybot_d[i] = YTOP_INIT + GAP_H_C;
      end
      left_d[i]  = clamp(p_d[i]);
      right_d[i] = clamp(p_d[i] + OBSW_C - 11'sd1);
    end

    if (passed) begin
      scored_d = 1'b1;
      if (score_q != 8'hFF) begin
        score_d = score_q + 8'd1;
      end
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= SEED_I;
      score_q   <= '0;
      scored_q  <= 1'b0;
      running_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        p_q[i]     <= p_init(i);
        ytop_q[i]  <= YTOP_INIT;
        ybot_q[i]  <= YTOP_INIT + GAP_H_C;
        left_q[i]  <= clamp(p_init(i));
        right_q[i] <= clamp(p_init(i) + OBSW_C - 11'sd1);
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      score_q   <= score_d;
      scored_q  <= scored_d;
      running_q <= running_d;
      for (int i = 0; i < 3; i++) begin
        p_q[i]     <= p_d[i];
        ytop_q[i]  <= ytop_d[i];
        ybot_q[i]  <= ybot_d[i];
        left_q[i]  <= left_d[i];
        right_q[i] <= right_d[i];
      end
    end
  end

  assign finalObsLeft1  = left_q[0];
  assign finalObsLeft2  = left_q[1];
  assign finalObsLeft3  = left_q[2];
  assign finalObsRight1 = right_q[0];
  assign finalObsRight2 = right_q[1];
  assign finalObsRight3 = right_q[2];
  assign finalYTop1     = ytop_q[0];
  assign finalYTop2     = ytop_q[1];
  assign finalYTop3     = ytop_q[2];
  assign finalYBot1     = ybot_q[0];
  assign finalYBot2     = ybot_q[1];
  assign finalYBot3     = ybot_q[2];
  assign running        = running_q;
  assign scored         = scored_q;
  assign score          = score_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller. Stimulus pushes expected values tagged with
// the cycle they must appear on; a monitor pops and compares on negedges.
// A second instance (TICK_DIV=2, STEP=40) reaches score saturation quickly.

module tb_obstacle_scroller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, collision, start2;

  logic [9:0] l1, l2, l3, r1, r2, r3;
  logic [8:0] yt1, yt2, yt3, yb1, yb2, yb3;
  logic       running, scored;
  logic [7:0] score;

  logic [9:0] b_l1, b_l2, b_l3, b_r1, b_r2, b_r3;
  logic [8:0] b_yt1, b_yt2, b_yt3, b_yb1, b_yb2, b_yb3;
  logic       b_running, b_scored;
  logic [7:0] b_score;

  obstacle_scroller #(.TICK_DIV(4), .STEP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .collision(collision),
    .finalObsLeft1(l1), .finalObsLeft2(l2), .finalObsLeft3(l3),
    .finalObsRight1(r1), .finalObsRight2(r2), .finalObsRight3(r3),
    .finalYTop1(yt1), .finalYTop2(yt2), .finalYTop3(yt3),
    .finalYBot1(yb1), .finalYBot2(yb2), .finalYBot3(yb3),
    .running(running), .scored(scored), .score(score)
  );

  obstacle_scroller #(.TICK_DIV(2), .STEP(40)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .collision(1'b0),
    .finalObsLeft1(b_l1), .finalObsLeft2(b_l2), .finalObsLeft3(b_l3),
    .finalObsRight1(b_r1), .finalObsRight2(b_r2), .finalObsRight3(b_r3),
    .finalYTop1(b_yt1), .finalYTop2(b_yt2), .finalYTop3(b_yt3),
    .finalYBot1(b_yb1), .finalYBot2(b_yb2), .finalYBot3(b_yb3),
    .running(b_running), .scored(b_scored), .score(b_score)
  );

  localparam int L1 = 0, R1 = 1, YT1 = 2, YB1 = 3, L2 = 4, L3 = 5, RUN = 6,
                 SCD = 7, SCR = 8, YT2 = 9, SCR2 = 10, SCD2 = 11, R3 = 12,
                 YB3 = 13;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: 16-bit Galois, x^16+x^14+x^13+x^11, seed ACE1.
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_m <= 16'hACE1;
    else        lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic expect_at(input int c, input int s, input int v, input string n);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  function automatic int actual(input int s);
    case (s)
      L1:   return int'(l1);
      R1:   return int'(r1);
      YT1:  return int'(yt1);
      YB1:  return int'(yb1);
      L2:   return int'(l2);
      L3:   return int'(l3);
      RUN:  return int'(running);
      SCD:  return int'(scored);
      SCR:  return int'(score);
      YT2:  return int'(yt2);
      SCR2: return int'(b_score);
      SCD2: return int'(b_scored);
      R3:   return int'(r3);
      YB3:  return int'(yb3);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d skipped at cycle %0d", e.name, e.cyc, cyc);
      end else if (actual(e.sig) != e.val) begin
        errors++;
        $display("FAIL %s @%0d: got %0d, expected %0d", e.name, cyc, actual(e.sig), e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  int c0, cs, cr, s2, g, budget;

  initial begin
    reset = 1'b0; start = 1'b0; collision = 1'b0; start2 = 1'b0;
    expect_at(2, L1, 640, "in_reset_left1");
    expect_at(2, RUN, 0, "in_reset_running");
    tick(3);
    reset = 1'b1;
    c0 = cyc;
    expect_at(c0 + 20, L1, 640, "idle_left1");
    expect_at(c0 + 20, L2, 800, "idle_left2");
    expect_at(c0 + 20, L3, 960, "idle_left3");
    expect_at(c0 + 20, R1, 679, "idle_right1");
    expect_at(c0 + 20, YT1, 180, "idle_ytop1");
    expect_at(c0 + 20, YB1, 300, "idle_ybot1");
    expect_at(c0 + 20, YB3, 300, "idle_ybot3");
    expect_at(c0 + 20, RUN, 0, "idle_running");
    expect_at(c0 + 20, SCD, 0, "idle_scored");
    tick(20);

    // Start: state RUN from edge cs, step k lands on edge cs+4k.
    start = 1'b1;
    cs = cyc + 1;
    expect_at(cs,     RUN, 1,   "start_running");
    expect_at(cs + 3, L1,  640, "no_early_step");
    expect_at(cs + 4, L1,  638, "step1_left1");
    expect_at(cs + 4, R1,  677, "step1_right1");
    expect_at(cs + 8, L1,  636, "step2_left1");
    expect_at(cs + 8, L2,  796, "step2_left2");
    expect_at(cs + 8, R3,  995, "step2_right3");
    tick(1);
    start = 1'b0;

    // Pipe 1 passes the bird column on step 290 (right 101 -> 99).
    expect_at(cs + 1159, SCD, 0,  "pre_score_pulse");
    expect_at(cs + 1159, SCR, 0,  "pre_score_count");
    expect_at(cs + 1160, L1,  60, "score_left1");
    expect_at(cs + 1160, R1,  99, "score_right1");
    expect_at(cs + 1160, SCD, 1,  "score_pulse");
    expect_at(cs + 1160, SCR, 1,  "score_count");
    expect_at(cs + 1161, SCD, 0,  "score_pulse_one_cycle");
    expect_at(cs + 1164, SCD, 0,  "no_repeat_pulse");
    expect_at(cs + 1164, SCR, 1,  "score_held");
    // Clamp at left edge.
    expect_at(cs + 1280, L1, 0,  "p0_left1");
    expect_at(cs + 1280, R1, 39, "p0_right1");
    expect_at(cs + 1356, L1, 0,  "clamp_left1");
    expect_at(cs + 1356, R1, 1,  "clamp_right1");

    // Respawn on step 340: the gap comes from the LFSR value held just before.
    wait_cyc(cs + 1359);
    g = int'(lfsr_m[7:0]);
    expect_at(cs + 1360, L1,  440,     "respawn_left1");
    expect_at(cs + 1360, R1,  479,     "respawn_right1");
    expect_at(cs + 1360, YT1, 40 + g,  "respawn_ytop1");
    expect_at(cs + 1360, YB1, 160 + g, "respawn_ybot1");
    expect_at(cs + 1360, YT2, 180,     "other_gap_kept");
    expect_at(cs + 1360, L2,  120,     "respawn_left2");
    expect_at(cs + 1480, SCR, 2,       "second_score");
    expect_at(cs + 1480, SCD, 1,       "second_pulse");
    expect_at(cs + 1483, RUN, 1,       "pre_collision_running");
    expect_at(cs + 1483, L1,  380,     "pre_collision_left1");

    // Collision coincides with tick edge cs+1484 (step 371): no movement.
    wait_cyc(cs + 1483);
    collision = 1'b1;
    expect_at(cs + 1484, RUN, 0,   "halt_running");
    expect_at(cs + 1484, L1,  380, "halt_no_step_left1");
    expect_at(cs + 1484, L2,  60,  "halt_no_step_left2");
    expect_at(cs + 1484, L3,  220, "halt_no_step_left3");
    expect_at(cs + 1584, L1,  380, "frozen_left1");
    expect_at(cs + 1584, L3,  220, "frozen_left3");
    expect_at(cs + 1584, SCR, 2,   "frozen_score");
    expect_at(cs + 1584, YT1, 40 + g, "frozen_ytop1");
    expect_at(cs + 1584, RUN, 0,   "frozen_running");

    wait_cyc(cs + 1600);
    start = 1'b1;
    expect_at(cs + 1601, RUN, 0,   "start_with_collision_ignored");
    expect_at(cs + 1601, L1,  380, "no_reload_with_collision");
    tick(1);
    start = 1'b0;
    tick(5);
    collision = 1'b0;
    start = 1'b1;
    cr = cyc + 1;
    expect_at(cr,     RUN, 1,   "restart_running");
    expect_at(cr,     L1,  640, "restart_left1");
    expect_at(cr,     L2,  800, "restart_left2");
    expect_at(cr,     SCR, 0,   "restart_score");
    expect_at(cr,     YT1, 180, "restart_ytop1");
    expect_at(cr,     YB1, 300, "restart_ybot1");
    expect_at(cr + 4, L1,  638, "restart_step1");
    tick(1);
    start = 1'b0;

    // Async reset between ticks: must show before the next clock edge.
    wait_cyc(cr + 6);
    expect_at(cr + 6, L1,  640, "async_reset_left1");
    expect_at(cr + 6, R1,  679, "async_reset_right1");
    expect_at(cr + 6, RUN, 0,   "async_reset_running");
    expect_at(cr + 6, SCD, 0,   "async_reset_scored");
    #2;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    expect_at(cyc + 10, L1,  640, "post_reset_idle_left1");
    expect_at(cyc + 10, RUN, 0,   "post_reset_idle_running");
    tick(12);

    // Second instance: step k on edge s2+2k, score n on step 15+4(n-1).
    start2 = 1'b1;
    s2 = cyc + 1;
    expect_at(s2 + 29,   SCR2, 0,   "fast_pre_first");
    expect_at(s2 + 30,   SCR2, 1,   "fast_first_score");
    expect_at(s2 + 30,   SCD2, 1,   "fast_first_pulse");
    expect_at(s2 + 1046, SCR2, 128, "fast_score_128");
    expect_at(s2 + 2061, SCR2, 254, "fast_score_254");
    expect_at(s2 + 2062, SCR2, 255, "fast_score_255");
    expect_at(s2 + 2062, SCD2, 1,   "fast_pulse_255");
    expect_at(s2 + 2070, SCD2, 1,   "saturated_pulse");
    expect_at(s2 + 2070, SCR2, 255, "saturated_score");
    expect_at(s2 + 2200, SCR2, 255, "saturated_hold");
    tick(1);
    start2 = 1'b0;

    wait_cyc(s2 + 2201);
    budget = 100;
    while (q.size() > 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d checks never reached, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
